// File: rtl/config_frame_loader_if.sv
// -----------------------------------------------------------------------------
// config_frame_loader_if
//
// Purpose:
//   Valid/ready word stream that carries the configuration bitstream into
//   config_frame_loader. One 32-bit word moves on every cycle in which
//   in_valid and in_ready are both high.
//
// Signals:
//   in_data   32  bitstream word (source -> loader)
//   in_valid   1  in_data holds a word (source -> loader)
//   in_ready   1  loader takes in_data this cycle (loader -> source)
//
// Modports:
//   master  bitstream source side (drives in_data / in_valid)
//   slave   loader side (drives in_ready)
// -----------------------------------------------------------------------------
interface config_frame_loader_if;

  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface : config_frame_loader_if

// File: rtl/config_frame_loader.sv
// -----------------------------------------------------------------------------
// config_frame_loader
//
// Purpose:
//   Front end of the fabric configuration path. Watches a 32-bit bitstream for
//   the sync pattern, decodes a frame header (column / frame address), gathers
//   one data word per fabric row, and then raises one one-hot FrameStrobe bit
//   for exactly one cycle. FrameData stays stable across that pulse so the
//   addressed column latches a complete frame. Headers that address a column or
//   frame outside the fabric have their data soaked up without a strobe, and
//   they set a sticky error flag. A header whose column byte is 8'hFF returns
//   the loader to sync hunting.
//
// Parameters:
//   MaxFramePerCol   frames per column (FrameStrobe bits per column)
//   FrameBitsPerRow  FrameData bits per row; equal to the 32-bit word width
//   NumRows          fabric rows = data words per frame
//   NumCols          fabric columns
//   SyncWord         sync pattern that starts a configuration session
//
// Ports:
//   UserCLK      in   1   clock, rising edge
//   resetn       in   1   asynchronous active-low reset
//   stream       slave    bitstream word stream (in_data / in_valid / in_ready)
//   FrameData    out  FrameBitsPerRow*NumRows   assembled frame, row r at
//                                               [32*r+31 : 32*r]
//   FrameStrobe  out  MaxFramePerCol*NumCols    one-hot write strobe; bit
//                                               index = col*MaxFramePerCol+frame
//   busy         out  1   loader is not hunting for sync
//   error        out  1   sticky bad-address flag; cleared by the next sync
//   frame_count  out  16  frames strobed so far, wraps at 2^16
// -----------------------------------------------------------------------------
module config_frame_loader #(
  parameter int          MaxFramePerCol  = 32,
  parameter int          FrameBitsPerRow = 32,
  parameter int          NumRows         = 3,
  parameter int          NumCols         = 3,
  parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1
) (
  input  logic                                UserCLK,
  input  logic                                resetn,
  config_frame_loader_if.slave                stream,
  output logic [FrameBitsPerRow*NumRows-1:0]  FrameData,
  output logic [MaxFramePerCol*NumCols-1:0]   FrameStrobe,
  output logic                                busy,
  output logic                                error,
  output logic [15:0]                         frame_count
);

  // Register widths for the latched address and the row counter. A width of
  // at least one bit keeps degenerate single-column / single-row builds legal.
  localparam int ColW   = (NumCols > 1)        ? $clog2(NumCols)        : 1;
  localparam int FrameW = (MaxFramePerCol > 1) ? $clog2(MaxFramePerCol) : 1;
  localparam int RowW   = (NumRows > 1)        ? $clog2(NumRows)        : 1;
  localparam int IdxW   = $clog2(MaxFramePerCol * NumCols);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2,
    STROBE = 2'd3
  } state_t;

  state_t              state;
  logic [ColW-1:0]     colReg;
  logic [FrameW-1:0]   frameReg;
  logic [RowW-1:0]     rowCnt;
  logic                discard;

  logic                accept;
  logic                isSync;
  logic [7:0]          hdrCol;
  logic [7:0]          hdrFrame;
  logic                hdrDesync;
  logic                hdrBad;
  logic                lastRow;
  logic [IdxW-1:0]     strobeIdx;
  logic [MaxFramePerCol*NumCols-1:0] strobeOneHot;

  // in_ready comes straight from the state register: the only cycle the
  // loader cannot take a word is the single strobe cycle.
  assign stream.in_ready = (state != STROBE);
  assign accept          = stream.in_valid && stream.in_ready;
  assign isSync          = (stream.in_data == SyncWord);

  // Header fields; the low half-word of a header is reserved.
  assign hdrCol    = stream.in_data[31:24];
  assign hdrFrame  = stream.in_data[23:16];
  assign hdrDesync = (hdrCol == 8'hFF);
  assign hdrBad    = (int'(hdrCol) >= NumCols) || (int'(hdrFrame) >= MaxFramePerCol);

  assign lastRow = (rowCnt == RowW'(NumRows - 1));

  // colReg/frameReg are range-checked before they are latched, so this index
  // always lands inside the strobe bus.
  assign strobeIdx = IdxW'(colReg) * IdxW'(MaxFramePerCol) + IdxW'(frameReg);

  always_comb begin
    strobeOneHot            = '0;
    strobeOneHot[strobeIdx] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Loader FSM with registered outputs.
  // FrameStrobe is loaded on the edge that accepts the last data word, so the
  // pulse lines up with the STROBE state and clears on the following edge.
  // frame_count advances on that same edge, so it already shows the new total
  // while the strobe is high.
  // ---------------------------------------------------------------------------
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      busy        <= 1'b0;
      error       <= 1'b0;
      discard     <= 1'b0;
      colReg      <= '0;
      frameReg    <= '0;
      rowCnt      <= '0;
      FrameData   <= '0;
      FrameStrobe <= '0;
      frame_count <= '0;
    end else begin
      FrameStrobe <= '0;

      case (state)
        IDLE: begin
          // Everything except the sync pattern is dropped while hunting.
          if (accept && isSync) begin
            error <= 1'b0;
            busy  <= 1'b1;
            state <= HEADER;
          end
        end

        HEADER: begin
          // Repeated sync words are padding and leave the loader in HEADER.
          if (accept && !isSync) begin
            if (hdrDesync) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else if (hdrBad) begin
              // Out-of-range address: consume the frame's data but never strobe.
              error   <= 1'b1;
              discard <= 1'b1;
              rowCnt  <= '0;
              state   <= DATA;
            end else begin
              colReg   <= hdrCol[ColW-1:0];
              frameReg <= hdrFrame[FrameW-1:0];
              discard  <= 1'b0;
              rowCnt   <= '0;
              state    <= DATA;
            end
          end
        end

        DATA: begin
          if (accept) begin
            FrameData[int'(rowCnt)*FrameBitsPerRow +: FrameBitsPerRow] <= stream.in_data;
            if (lastRow) begin
              rowCnt <= '0;
              if (discard) begin
                state <= HEADER;
              end else begin
                FrameStrobe <= strobeOneHot;
                frame_count <= frame_count + 16'd1;
                state       <= STROBE;
              end
            end else begin
              rowCnt <= rowCnt + RowW'(1);
            end
          end
        end

        STROBE: begin
          // Always exactly one cycle, independent of in_valid.
          state <= HEADER;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : config_frame_loader

// File: doc/config_frame_loader.md
# config_frame_loader

Upstream configuration stage for the fabric top level: consumes a 32-bit bitstream word stream over a valid/ready handshake, assembles one configuration frame at a time, and drives the fabric's flat FrameData and FrameStrobe buses. Each completed frame produces exactly one single-cycle one-hot FrameStrobe pulse. FrameData is held stable through that pulse, and the addressed column latches it. Sync detection, frame addressing, address checking and desync are handled here, so the fabric sees only clean strobe/data pairs.

## Interface

Parameters:
- MaxFramePerCol, 32, frames per column; FrameStrobe width per column.
- FrameBitsPerRow, 32, FrameData bits per row; fixed at 32, equal to the stream word width.
- NumRows, 3, fabric rows; one data word per row per frame.
- NumCols, 3, fabric columns.
- SyncWord, 32'hFAB0_FAB1, stream sync pattern.

Ports:
- UserCLK  input  1  clock; all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- in_data  input  32  bitstream word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts in_data this cycle.
- FrameData  output  FrameBitsPerRow*NumRows  assembled frame; row r occupies bits [32*r+31:32*r].
- FrameStrobe  output  MaxFramePerCol*NumCols  one-hot write strobe; bit index = col*MaxFramePerCol + frame.
- busy  output  1  high in any state other than IDLE.
- error  output  1  sticky; set by a bad frame address.
- frame_count  output  16  count of frames strobed; wraps at 2^16.

## Operation

- A word is accepted when in_valid && in_ready.
- in_ready = 0 in STROBE and 1 in all other states.
- IDLE:
  - Accepted words other than SyncWord are discarded.
  - Accepting SyncWord clears error and moves to HEADER.
- HEADER: accepted word is decoded as col = [31:24], frame = [23:16]; bits [15:0] are ignored.
  - Word == SyncWord: ignored; stay in HEADER.
  - col == 8'hFF: desync; go to IDLE.
  - col >= NumCols or frame >= MaxFramePerCol: set error, set the internal `discard` flag, go to DATA.
  - Otherwise: latch col and frame, clear `discard`, go to DATA.
- DATA:
  - Row counter starts at 0 on entry.
  - Each accepted word is written to FrameData row[row_cnt], then row_cnt increments.
  - When the word for row NumRows-1 is accepted:
    - go to STROBE if `discard` = 0;
    - go to HEADER if `discard` = 1, with no strobe and frame_count unchanged.
- STROBE (exactly one cycle):
  - FrameStrobe[col*MaxFramePerCol+frame] = 1; all other bits 0.
  - frame_count increments.
  - Next state is HEADER.
- FrameStrobe is 0 in every state except STROBE.
- FrameData is registered and changes only when a DATA word is accepted.
  - It therefore stays stable from the last row write, through STROBE, until the next frame's first data word is accepted.
- Discarded frames still overwrite FrameData; this is harmless because no strobe accompanies them.
- error stays set until resetn asserts or a SyncWord is accepted in IDLE.
- Strobe index arithmetic uses an unsigned width of clog2(MaxFramePerCol*NumCols). col and frame are range-checked before use, so the index never overflows.

## Timing

- Reset (resetn low, asynchronous), values applied immediately:
  - state = IDLE; in_ready = 1; busy = 0; error = 0.
  - FrameData = 0; FrameStrobe = 0; frame_count = 0; row_cnt = 0.
- Reset asserted mid-frame aborts the frame; no strobe is issued. After release, the loader requires a new SyncWord.
- Latency: FrameStrobe is high in the cycle immediately after the edge that accepts the last data word.
- Minimum frame period is 1 header + NumRows data + 1 strobe = NumRows+2 cycles (5 for the default parameters).
- in_valid low in any state: no state change and no output change, except that STROBE always completes.
- in_valid and in_data may be held across the STROBE cycle. That word is accepted on the following cycle, as a header.
- Outputs FrameStrobe, FrameData, busy, error and frame_count are all registered; in_ready is decoded from the state register.

## Test plan

- Reset then idle: resetn low for 3 cycles, then release → all outputs 0 except in_ready = 1; words 32'h1234_5678 and 32'h0 in IDLE are dropped and busy stays 0.
- Nominal frame: SyncWord, header 32'h0105_0000, then data 32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2 on consecutive cycles →
  - FrameStrobe bit 37 high for exactly one cycle, one cycle after the last word;
  - FrameData = {C2C2C2C2, B1B1B1B1, A0A0A0A0};
  - in_ready low in that cycle; frame_count = 1.
- Backpressure and gaps: same frame with in_valid toggling randomly; in_valid held high through STROBE with the next header 32'h0200_0000 → that header is accepted after STROBE; the second frame strobes bit 64.
- Bad address: header 32'h0300_0000 (col 3) followed by 3 data words → no strobe; error = 1; frame_count unchanged; state returns to HEADER. A following valid frame still strobes correctly.
- Desync and resync: header 32'hFF00_0000 → busy = 0; next data-looking word is ignored; SyncWord clears error.
- Reset mid-DATA after 2 of 3 data words → FrameStrobe never pulses; outputs return to reset values; a full frame after a fresh SyncWord completes normally.
